lab9_soc_nios2_qsys_0_oci_dct_ctrl: RTL and testbench



---
 rtl/lab9_soc_nios2_qsys_0_oci_dct_pkg.sv | 24 ++
 rtl/lab9_soc_nios2_qsys_0_oci_dct_frame_reg.sv | 45 ++++
 rtl/lab9_soc_nios2_qsys_0_oci_dct_ctrl.sv | 115 +++++++++++
 tb/tb_lab9_soc_nios2_qsys_0_oci_dct_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab9_soc_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants and types for the OCI DCT packing controller.
// Frames are {count, buffer}; the FSM sequences normal run, end-of-test drain and done.
package lab9_soc_nios2_qsys_0_oci_dct_pkg;

  localparam int ATOM_W  = 2;
  localparam int ATOMS   = 15;
  localparam int CNT_W   = 4;
  localparam int BUF_W   = ATOM_W * ATOMS;
  localparam int FRAME_W = CNT_W + BUF_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ATOMS);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } dct_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
  } dct_frame_t;

endpackage

// File: rtl/lab9_soc_nios2_qsys_0_oci_dct_frame_reg.sv
// Single-entry frame holding register toward the trace-memory writer.
// Data is only replaced on load, so it stays stable while valid and not yet accepted.
module lab9_soc_nios2_qsys_0_oci_dct_frame_reg
  import lab9_soc_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  dct_frame_t load_data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output dct_frame_t data_o,
  output logic       out_free_o
);

  logic       valid_q, valid_d;
  dct_frame_t data_q, data_d;

  assign out_free_o = !valid_q || ready_i;
  assign valid_o    = valid_q;
  assign data_o     = data_q;

  // A load wins over a same-cycle accept so back-to-back frames keep valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lab9_soc_nios2_qsys_0_oci_dct_ctrl.sv
// OCI DCT packing controller: packs 2-bit atoms into 15-atom frames, handles flush
// requests and the end-of-test drain, then reports test_has_ended.
module lab9_soc_nios2_qsys_0_oci_dct_ctrl
  import lab9_soc_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               atom_valid,
  input  logic [ATOM_W-1:0]  atom_data,
  output logic               atom_ready,
  input  logic               flush_req,
  input  logic               test_ending,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic [FRAME_W-1:0] frame_data,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               test_has_ended
);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic             out_free;
  logic             full;
  logic             has_data;
  logic             flush_active;
  logic             accept;
  logic             xfer;
  logic [CNT_W-1:0] slot_idx;
  logic [ATOMS-1:0] slot_we;
  dct_frame_t       frame_in;
  dct_frame_t       frame_out;

  assign full     = (cnt_q == CNT_FULL);
  assign has_data = (cnt_q != '0);

  // A flush waits for the holding register; it only matters while atoms are buffered.
  assign flush_active = (state_q == RUN) && has_data && (flush_req || flush_pend_q);

  assign atom_ready = (state_q == RUN) && (!full || out_free) && !flush_req && !flush_pend_q;
  assign accept     = atom_valid && atom_ready;
  assign xfer       = out_free && has_data && (full || flush_active || (state_q == DRAIN));

  // An atom accepted together with a transfer starts the new frame at slot 0.
  assign slot_idx = xfer ? '0 : cnt_q;

  for (genvar gi = 0; gi < ATOMS; gi++) begin : g_slot
    assign slot_we[gi] = accept && (slot_idx == CNT_W'(gi));
    assign buf_d[ATOM_W*gi +: ATOM_W] =
      slot_we[gi] ? atom_data : (xfer ? '0 : buf_q[ATOM_W*gi +: ATOM_W]);
  end

  always_comb begin
    cnt_d = xfer ? '0 : cnt_q;
    if (accept) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_comb begin
    flush_pend_d = flush_pend_q;
    if ((state_q != RUN) || xfer) begin
      flush_pend_d = 1'b0;
    end else if (flush_req && has_data) begin
      flush_pend_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (test_ending) state_d = DRAIN;
      DRAIN:   if (!has_data && !frame_valid) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign frame_in.count  = cnt_q;
  assign frame_in.buffer = buf_q;

  lab9_soc_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (xfer),
    .load_data_i (frame_in),
    .ready_i     (frame_ready),
    .valid_o     (frame_valid),
    .data_o      (frame_out),
    .out_free_o  (out_free)
  );

  assign frame_data     = frame_out;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign test_has_ended = (state_q == DONE);

endmodule

// File: tb/tb_lab9_soc_nios2_qsys_0_oci_dct_ctrl.sv
// Scoreboard bench: a list-based frame model predicts frames from observed atom
// handshakes, flushes and test_ending; a monitor compares frames as the writer takes them.
module tb_lab9_soc_nios2_qsys_0_oci_dct_ctrl;
  import lab9_soc_nios2_qsys_0_oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom_data;
  logic        atom_ready;
  logic        flush_req;
  logic        test_ending;
  logic        frame_valid;
  logic        frame_ready;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        test_has_ended;

  int checks = 0;
  int passes = 0;

  logic [1:0]  live_q[$];
  logic [33:0] exp_q[$];
  bit          running = 1'b1;

  lab9_soc_nios2_qsys_0_oci_dct_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom_data      (atom_data),
    .atom_ready     (atom_ready),
    .flush_req      (flush_req),
    .test_ending    (test_ending),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .frame_data     (frame_data),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Atom k of a frame lives at bits [2k+1:2k]; the count is the number of atoms.
  function automatic logic [33:0] pack(input logic [1:0] a[$]);
    logic [29:0] b;
    b = '0;
    foreach (a[k]) b[2*k +: 2] = a[k];
    return {4'(a.size()), b};
  endfunction

  always @(negedge clk) begin : model
    if (!reset_n) begin
      live_q.delete();
      exp_q.delete();
      running = 1'b1;
    end else begin
      if (atom_valid && atom_ready) begin
        check("accept_allowed", 64'(running), 64'(1));
        if (running) begin
          live_q.push_back(atom_data);
          if (live_q.size() == ATOMS) begin
            exp_q.push_back(pack(live_q));
            $display("model: full frame %h queued", pack(live_q));
            live_q.delete();
          end
        end
      end
      if (running && flush_req && live_q.size() != 0) begin
        exp_q.push_back(pack(live_q));
        $display("model: flush frame %h queued", pack(live_q));
        live_q.delete();
      end
      if (running && test_ending) begin
        if (live_q.size() != 0) begin
          exp_q.push_back(pack(live_q));
          $display("model: drain frame %h queued", pack(live_q));
          live_q.delete();
        end
        running = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic        hold_prev;
    logic [33:0] hold_data;
    logic        ended_seen;
    logic [33:0] exp;
    if (!reset_n) begin
      hold_prev  = 1'b0;
      hold_data  = '0;
      ended_seen = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", 64'(frame_valid), 64'(1));
        check("hold_stable", 64'(frame_data), 64'(hold_data));
      end
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: got 0x%0h, required no frame", frame_data);
        end else begin
          exp = exp_q.pop_front();
          $display("frame accepted: got %h expected %h", frame_data, exp);
          check("frame", 64'(frame_data), 64'(exp));
        end
      end
      hold_prev = frame_valid && !frame_ready;
      hold_data = frame_data;
      if (test_has_ended && !ended_seen) begin
        ended_seen = 1'b1;
        check("ended_after_drain", 64'(exp_q.size()), 64'(0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_atom(input logic [1:0] d, output int waited);
    waited     = 0;
    atom_valid = 1'b1;
    atom_data  = d;
    @(negedge clk);
    while (!atom_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!atom_ready) check("atom_accept_timeout", 64'(atom_ready), 64'(1));
    @(posedge clk);
    #1;
    atom_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    int          waited;
    int          total_wait;
    int          n;
    logic [1:0]  d;
    logic [33:0] exp_flush;

    reset_n = 1'b0; atom_valid = 1'b0; atom_data = 2'b00;
    flush_req = 1'b0; test_ending = 1'b0; frame_ready = 1'b0;
    step(); step();
    check("rst_count", 64'(dct_count), 64'(0));
    check("rst_buffer", 64'(dct_buffer), 64'(0));
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_frame_data", 64'(frame_data), 64'(0));
    check("rst_ended", 64'(test_has_ended), 64'(0));
    reset_n = 1'b1;
    step();
    check("rst_atom_ready", 64'(atom_ready), 64'(1));

    // Fifteen atoms with an always-ready writer.
    frame_ready = 1'b1;
    total_wait  = 0;
    for (int k = 0; k < 15; k++) begin
      send_atom(2'(k % 4), waited);
      total_wait += waited;
    end
    step(); step();
    check("full_ready_never_dropped", 64'(total_wait), 64'(0));
    check("full_count_cleared", 64'(dct_count), 64'(0));

    // Three atoms then a flush.
    send_atom(2'b11, waited);
    send_atom(2'b10, waited);
    send_atom(2'b01, waited);
    flush_req = 1'b1;
    @(negedge clk);
    check("ready_low_on_flush", 64'(atom_ready), 64'(0));
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 0;
    while (!frame_valid && n < 20) begin step(); n++; end
    exp_flush = {4'h3, 24'h0, 6'b01_10_11};
    check("flush_frame", 64'(frame_data), 64'(exp_flush));
    check("flush_count_cleared", 64'(dct_count), 64'(0));
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step(); step();
    check("empty_flush_no_frame", 64'(frame_valid), 64'(0));

    // Writer stalled: one held frame plus a full buffer, then release.
    frame_ready = 1'b0;
    for (int k = 0; k < 30; k++) send_atom(2'($urandom_range(0, 3)), waited);
    check("bp_count_full", 64'(dct_count), 64'(15));
    check("bp_frame_held", 64'(frame_valid), 64'(1));
    d = 2'($urandom_range(1, 3));
    atom_valid = 1'b1;
    atom_data  = d;
    repeat (3) @(negedge clk);
    check("bp_ready_low", 64'(atom_ready), 64'(0));
    @(posedge clk); #1;
    frame_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_on_release", 64'(atom_ready), 64'(1));
    @(posedge clk); #1;
    atom_valid = 1'b0;
    check("bp_count_after_release", 64'(dct_count), 64'(1));
    check("bp_atom_slot0", 64'(dct_buffer), 64'({28'h0, d}));
    check("bp_second_frame_loaded", 64'(frame_valid), 64'(1));
    wait_empty("bp_drain");

    // Randomised traffic with flushes and writer stalls.
    repeat (600) begin
      atom_valid  = ($urandom_range(0, 3) != 0);
      atom_data   = 2'($urandom_range(0, 3));
      flush_req   = ($urandom_range(0, 15) == 0);
      frame_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    atom_valid = 1'b0; flush_req = 1'b0; frame_ready = 1'b1;
    step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    wait_empty("random_drain");
    check("random_count_zero", 64'(dct_count), 64'(0));

    // End-of-test drain with a held frame and five buffered atoms.
    frame_ready = 1'b0;
    for (int k = 0; k < 20; k++) send_atom(2'($urandom_range(0, 3)), waited);
    check("drain_pre_count", 64'(dct_count), 64'(5));
    check("drain_pre_valid", 64'(frame_valid), 64'(1));
    test_ending = 1'b1;
    step();
    atom_valid = 1'b1;
    atom_data  = 2'($urandom_range(0, 3));
    @(negedge clk);
    check("drain_ready_low", 64'(atom_ready), 64'(0));
    repeat (4) step();
    check("drain_not_ended_while_blocked", 64'(test_has_ended), 64'(0));
    frame_ready = 1'b1;
    n = 0;
    while (!test_has_ended && n < 50) begin step(); n++; end
    check("drain_ended", 64'(test_has_ended), 64'(1));
    test_ending = 1'b0;
    repeat (3) step();
    check("ended_sticky", 64'(test_has_ended), 64'(1));
    check("done_ready_low", 64'(atom_ready), 64'(0));
    atom_valid = 1'b0;

    // Reset out of DONE, then an asynchronous reset mid-frame.
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("post_done_reset_ended", 64'(test_has_ended), 64'(0));
    check("post_done_ready", 64'(atom_ready), 64'(1));
    frame_ready = 1'b0;
    for (int k = 0; k < 22; k++) send_atom(2'($urandom_range(0, 3)), waited);
    check("arst_pre_count", 64'(dct_count), 64'(7));
    check("arst_pre_valid", 64'(frame_valid), 64'(1));
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_count", 64'(dct_count), 64'(0));
    check("arst_buffer", 64'(dct_buffer), 64'(0));
    check("arst_frame_valid", 64'(frame_valid), 64'(0));
    check("arst_frame_data", 64'(frame_data), 64'(0));
    check("arst_ended", 64'(test_has_ended), 64'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("arst_ready_run", 64'(atom_ready), 64'(1));
    frame_ready = 1'b1;
    send_atom(2'b10, waited);
    check("arst_next_count", 64'(dct_count), 64'(1));
    check("arst_next_slot0", 64'(dct_buffer), 64'(30'h2));
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    wait_empty("final_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
